// File: rtl/regfile_mp_sb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_mp_sb_if                                                     |
// | Read, write, reserve and debug signals of the multi-port regfile.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface regfile_mp_sb_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int NUM_RD   = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr0_en;
  logic [AW-1:0]            wr0_addr;
  logic [DATA_W-1:0]        wr0_data;
  logic                     wr1_en;
  logic [AW-1:0]            wr1_addr;
  logic [DATA_W-1:0]        wr1_data;
  logic                     rsv_en;
  logic [AW-1:0]            rsv_addr;
  logic                     rsv_ack;
  logic [NUM_REGS-1:0]      busy_vec;
  logic [AW-1:0]            dbg_addr;
  logic [DATA_W-1:0]        dbg_data;

  modport master (
    output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           rsv_en, rsv_addr, dbg_addr,
    input  rd_data, rd_busy, rsv_ack, busy_vec, dbg_data
  );

  modport slave (
    input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           rsv_en, rsv_addr, dbg_addr,
    output rd_data, rd_busy, rsv_ack, busy_vec, dbg_data
  );
endinterface
`default_nettype wire

// File: rtl/regfile_mp_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_mp_sb                                                        |
// | Multi-port register file with write bypass and busy scoreboard.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module regfile_mp_sb #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int NUM_RD   = 2,
  parameter int ZERO_R0  = 0,
  parameter int BYPASS   = 1
) (
  input  wire logic      clk,
  input  wire logic      reset,
  regfile_mp_sb_if.slave bus
);
  localparam int            AW   = $clog2(NUM_REGS);
  localparam logic [AW-1:0] c_r0 = '0;

  logic [DATA_W-1:0]   r_mem [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic                r_rsv_ack;
  logic [DATA_W-1:0]   r_dbg_data;

  logic                w_wr0_en, w_wr1_en, w_rsv_en;
  logic [AW-1:0]       w_wr0_addr, w_wr1_addr, w_rsv_addr, w_dbg_addr;
  logic [DATA_W-1:0]   w_wr0_data, w_wr1_data, w_dbg_data;
  logic                w_wr0_ok, w_wr1_ok, w_rsv_accept;
  logic [NUM_REGS-1:0] w_clr, w_set, w_busy_next;

  assign w_wr0_en   = bus.wr0_en;
  assign w_wr0_addr = bus.wr0_addr;
  assign w_wr0_data = bus.wr0_data;
  assign w_wr1_en   = bus.wr1_en;
  assign w_wr1_addr = bus.wr1_addr;
  assign w_wr1_data = bus.wr1_data;
  assign w_rsv_en   = bus.rsv_en;
  assign w_rsv_addr = bus.rsv_addr;
  assign w_dbg_addr = bus.dbg_addr;

  // wr1 is silently dropped when wr0 targets the same register
  assign w_wr0_ok = w_wr0_en && !(ZERO_R0 != 0 && w_wr0_addr == c_r0);
  assign w_wr1_ok = w_wr1_en && !(w_wr0_en && w_wr1_addr == w_wr0_addr)
                             && !(ZERO_R0 != 0 && w_wr1_addr == c_r0);

  function automatic logic [DATA_W-1:0] f_read(input logic [AW-1:0] a);
    logic [DATA_W-1:0] v;
    v = r_mem[a];
    if (BYPASS != 0) begin
      if (w_wr0_en && w_wr0_addr == a)      v = w_wr0_data;
      else if (w_wr1_en && w_wr1_addr == a) v = w_wr1_data;
    end
    if (ZERO_R0 != 0 && a == c_r0) v = '0;
    return v;
  endfunction

  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      assign bus.rd_data[k*DATA_W +: DATA_W] = f_read(bus.rd_addr[k*AW +: AW]);
      assign bus.rd_busy[k]                  = r_busy[bus.rd_addr[k*AW +: AW]];
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_sb
      assign w_clr[i] = (w_wr0_ok && w_wr0_addr == AW'(i)) ||
                        (w_wr1_ok && w_wr1_addr == AW'(i));
      assign w_set[i] = w_rsv_accept && w_rsv_addr == AW'(i) &&
                        !(ZERO_R0 != 0 && i == 0);
    end
  endgenerate

  // A register being released this cycle may be re-reserved in the same cycle
  assign w_rsv_accept = w_rsv_en && (!r_busy[w_rsv_addr] || w_clr[w_rsv_addr]);
  assign w_busy_next  = w_set | (r_busy & ~w_clr);
  assign w_dbg_data   = f_read(w_dbg_addr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
      r_busy     <= '0;
      r_rsv_ack  <= 1'b0;
      r_dbg_data <= '0;
    end else begin
      if (w_wr1_ok) r_mem[w_wr1_addr] <= w_wr1_data;
      if (w_wr0_ok) r_mem[w_wr0_addr] <= w_wr0_data;
      r_busy     <= w_busy_next;
      r_rsv_ack  <= w_rsv_accept;
      r_dbg_data <= w_dbg_data;
    end
  end

  assign bus.busy_vec = r_busy;
  assign bus.rsv_ack  = r_rsv_ack;
  assign bus.dbg_data = r_dbg_data;
endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_regfile_mp_sb                                                     |
// | Bench for regfile_mp_sb: default, no-bypass and zero-R0 variants.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_regfile_mp_sb;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rd_addr;
  logic        wr0_en, wr1_en, rsv_en;
  logic [3:0]  wr0_addr, wr1_addr, rsv_addr, dbg_addr;
  logic [15:0] wr0_data, wr1_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          inst;
    logic        ack;
    logic [15:0] dbg;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  regfile_mp_sb_if #(.DATA_W(16), .NUM_REGS(16), .NUM_RD(2)) bus_a ();
  regfile_mp_sb_if #(.DATA_W(16), .NUM_REGS(16), .NUM_RD(2)) bus_n ();
  regfile_mp_sb_if #(.DATA_W(16), .NUM_REGS(16), .NUM_RD(2)) bus_z ();

`define TB_DRIVE(b) \
  assign b.rd_addr  = rd_addr;  \
  assign b.wr0_en   = wr0_en;   \
  assign b.wr0_addr = wr0_addr; \
  assign b.wr0_data = wr0_data; \
  assign b.wr1_en   = wr1_en;   \
  assign b.wr1_addr = wr1_addr; \
  assign b.wr1_data = wr1_data; \
  assign b.rsv_en   = rsv_en;   \
  assign b.rsv_addr = rsv_addr; \
  assign b.dbg_addr = dbg_addr;

  `TB_DRIVE(bus_a)
  `TB_DRIVE(bus_n)
  `TB_DRIVE(bus_z)
`undef TB_DRIVE

  regfile_mp_sb #(.DATA_W(16), .NUM_REGS(16), .NUM_RD(2), .ZERO_R0(0), .BYPASS(1))
    u_a (.clk(clk), .reset(reset), .bus(bus_a));
  regfile_mp_sb #(.DATA_W(16), .NUM_REGS(16), .NUM_RD(2), .ZERO_R0(0), .BYPASS(0))
    u_n (.clk(clk), .reset(reset), .bus(bus_n));
  regfile_mp_sb #(.DATA_W(16), .NUM_REGS(16), .NUM_RD(2), .ZERO_R0(1), .BYPASS(1))
    u_z (.clk(clk), .reset(reset), .bus(bus_z));

  // Registered outputs are compared one edge after their expectation is queued
  exp_t        m_e;
  logic        m_ack;
  logic [15:0] m_dbg;
  always @(posedge clk) begin
    #1;
    while (q.size() > 0) begin
      m_e = q.pop_front();
      case (m_e.inst)
        0:       begin m_ack = bus_a.rsv_ack; m_dbg = bus_a.dbg_data; end
        1:       begin m_ack = bus_n.rsv_ack; m_dbg = bus_n.dbg_data; end
        default: begin m_ack = bus_z.rsv_ack; m_dbg = bus_z.dbg_data; end
      endcase
      total++;
      if ({m_ack, m_dbg} !== {m_e.ack, m_e.dbg}) begin
        bad++;
        $display("FAIL sb_inst%0d ack/dbg got %b/%h want %b/%h",
                 m_e.inst, m_ack, m_dbg, m_e.ack, m_e.dbg);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic idle();
    wr0_en = 1'b0; wr1_en = 1'b0; rsv_en = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({bus_a.rd_data, bus_a.busy_vec, bus_a.rsv_ack, bus_a.dbg_data} !== 65'd0) begin
      bad++;
      $display("FAIL reset_state got rd=%h busy=%h ack=%b dbg=%h want all zero",
               bus_a.rd_data, bus_a.busy_vec, bus_a.rsv_ack, bus_a.dbg_data);
    end
    @(negedge clk);
    reset = 1'b1;
    wr0_en = 1'b1; wr0_addr = 4'd1; wr0_data = 16'h1234;
    rsv_en = 1'b1; rsv_addr = 4'd2; rd_addr = {4'd2, 4'd1};
    @(posedge clk); #1;
    idle();
    #1;
    total++;
    if ({bus_a.rd_data[15:0], bus_a.busy_vec, bus_a.rsv_ack} !== {16'h1234, 16'h0004, 1'b1}) begin
      bad++;
      $display("FAIL pre_reset_state got rd=%h busy=%h ack=%b want 1234/0004/1",
               bus_a.rd_data[15:0], bus_a.busy_vec, bus_a.rsv_ack);
    end
    reset = 1'b0;
    #1;
    total++;
    if ({bus_a.rd_data, bus_a.busy_vec, bus_a.rsv_ack, bus_z.busy_vec} !== 65'd0) begin
      bad++;
      $display("FAIL async_reset got rd=%h busy=%h ack=%b want zero while clk high",
               bus_a.rd_data, bus_a.busy_vec, bus_a.rsv_ack);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_bypass();
    @(negedge clk);
    wr0_en = 1'b1; wr0_addr = 4'd3; wr0_data = 16'hBEEF;
    rd_addr = {4'd0, 4'd3}; dbg_addr = 4'd3;
    q.push_back('{0, 1'b0, 16'hBEEF});
    q.push_back('{1, 1'b0, 16'h0000});
    q.push_back('{2, 1'b0, 16'hBEEF});
    #1;
    total++;
    if ({bus_a.rd_data[15:0], bus_n.rd_data[15:0]} !== {16'hBEEF, 16'h0000}) begin
      bad++;
      $display("FAIL bypass_pre got byp=%h nobyp=%h want BEEF/0000",
               bus_a.rd_data[15:0], bus_n.rd_data[15:0]);
    end
    @(posedge clk); #1;
    idle();
    #1;
    total++;
    if ({bus_a.rd_data[15:0], bus_n.rd_data[15:0]} !== {16'hBEEF, 16'hBEEF}) begin
      bad++;
      $display("FAIL bypass_post got byp=%h nobyp=%h want BEEF/BEEF",
               bus_a.rd_data[15:0], bus_n.rd_data[15:0]);
    end
  endtask

  task automatic test_priority();
    @(negedge clk);
    wr0_en = 1'b1; wr0_addr = 4'd5; wr0_data = 16'h1111;
    wr1_en = 1'b1; wr1_addr = 4'd5; wr1_data = 16'h2222;
    rd_addr = {4'd6, 4'd5}; dbg_addr = 4'd5;
    q.push_back('{0, 1'b0, 16'h1111});
    q.push_back('{1, 1'b0, 16'h0000});
    #1;
    total++;
    if (bus_a.rd_data[15:0] !== 16'h1111) begin
      bad++;
      $display("FAIL prio_bypass got %h want 1111", bus_a.rd_data[15:0]);
    end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    wr1_en = 1'b1; wr1_addr = 4'd6; wr1_data = 16'h2222; dbg_addr = 4'd3;
    q.push_back('{0, 1'b0, 16'hBEEF});
    #1;
    total++;
    if ({bus_a.rd_data, bus_n.rd_data} !== {16'h2222, 16'h1111, 16'h0000, 16'h1111}) begin
      bad++;
      $display("FAIL prio_store got byp=%h nobyp=%h want 22221111/00001111",
               bus_a.rd_data, bus_n.rd_data);
    end
    @(posedge clk); #1;
    idle();
    #1;
    total++;
    if ({bus_a.rd_data[31:16], bus_n.rd_data[31:16]} !== {16'h2222, 16'h2222}) begin
      bad++;
      $display("FAIL wr1_alone got byp=%h nobyp=%h want 2222/2222",
               bus_a.rd_data[31:16], bus_n.rd_data[31:16]);
    end
  endtask

  task automatic test_reserve();
    @(negedge clk);
    rsv_en = 1'b1; rsv_addr = 4'd7; rd_addr = {4'd0, 4'd7};
    q.push_back('{0, 1'b1, 16'hBEEF});
    q.push_back('{2, 1'b1, 16'hBEEF});
    #1;
    total++;
    if (bus_a.rd_busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL rsv_pre_busy got %b want 0", bus_a.rd_busy[0]);
    end
    @(posedge clk); #1;
    idle();
    #1;
    total++;
    if ({bus_a.busy_vec, bus_a.rd_busy[0]} !== {16'h0080, 1'b1}) begin
      bad++;
      $display("FAIL rsv_set got busy=%h rd_busy=%b want 0080/1",
               bus_a.busy_vec, bus_a.rd_busy[0]);
    end
    @(negedge clk);
    rsv_en = 1'b1; rsv_addr = 4'd7;
    q.push_back('{0, 1'b0, 16'hBEEF});
    @(posedge clk); #1;
    idle();
    #1;
    total++;
    if (bus_a.busy_vec !== 16'h0080) begin
      bad++;
      $display("FAIL rsv_reject got busy=%h want 0080", bus_a.busy_vec);
    end
    @(negedge clk);
    wr1_en = 1'b1; wr1_addr = 4'd7; wr1_data = 16'h00A5;
    q.push_back('{0, 1'b0, 16'hBEEF});
    #1;
    total++;
    if ({bus_a.rd_busy[0], bus_a.rd_data[15:0]} !== {1'b1, 16'h00A5}) begin
      bad++;
      $display("FAIL rsv_wr_pre got rd_busy=%b rd=%h want 1/00A5",
               bus_a.rd_busy[0], bus_a.rd_data[15:0]);
    end
    @(posedge clk); #1;
    idle();
    #1;
    total++;
    if ({bus_a.busy_vec, bus_a.rd_data[15:0]} !== {16'h0000, 16'h00A5}) begin
      bad++;
      $display("FAIL rsv_release got busy=%h rd=%h want 0000/00A5",
               bus_a.busy_vec, bus_a.rd_data[15:0]);
    end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    rsv_en = 1'b1; rsv_addr = 4'd4; rd_addr = {4'd0, 4'd4};
    q.push_back('{0, 1'b1, 16'hBEEF});
    @(posedge clk); #1;
    idle();
    #1;
    total++;
    if (bus_a.busy_vec !== 16'h0010) begin
      bad++;
      $display("FAIL same_rsv got busy=%h want 0010", bus_a.busy_vec);
    end
    @(negedge clk);
    wr0_en = 1'b1; wr0_addr = 4'd4; wr0_data = 16'h4444;
    rsv_en = 1'b1; rsv_addr = 4'd4;
    q.push_back('{0, 1'b1, 16'hBEEF});
    @(posedge clk); #1;
    idle();
    #1;
    total++;
    if ({bus_a.busy_vec, bus_a.rd_data[15:0]} !== {16'h0010, 16'h4444}) begin
      bad++;
      $display("FAIL same_cycle got busy=%h rd=%h want 0010/4444",
               bus_a.busy_vec, bus_a.rd_data[15:0]);
    end
  endtask

  task automatic test_zero_r0();
    @(negedge clk);
    wr0_en = 1'b1; wr0_addr = 4'd0; wr0_data = 16'hFFFF;
    rsv_en = 1'b1; rsv_addr = 4'd0; rd_addr = {4'd0, 4'd0}; dbg_addr = 4'd0;
    q.push_back('{2, 1'b1, 16'h0000});
    q.push_back('{0, 1'b1, 16'hFFFF});
    #1;
    total++;
    if ({bus_z.rd_data[15:0], bus_a.rd_data[15:0]} !== {16'h0000, 16'hFFFF}) begin
      bad++;
      $display("FAIL r0_pre got zero=%h normal=%h want 0000/FFFF",
               bus_z.rd_data[15:0], bus_a.rd_data[15:0]);
    end
    @(posedge clk); #1;
    idle();
    #1;
    total++;
    if ({bus_z.busy_vec, bus_z.rd_data[15:0], bus_a.busy_vec} !== {16'h0010, 16'h0000, 16'h0011}) begin
      bad++;
      $display("FAIL r0_post got zbusy=%h zrd=%h abusy=%h want 0010/0000/0011",
               bus_z.busy_vec, bus_z.rd_data[15:0], bus_a.busy_vec);
    end
    @(negedge clk);
    dbg_addr = 4'd3;
    q.push_back('{2, 1'b0, 16'hBEEF});
    @(posedge clk);
  endtask

  initial begin
    reset = 1'b1;
    rd_addr = '0; dbg_addr = '0;
    wr0_addr = '0; wr0_data = '0; wr1_addr = '0; wr1_data = '0; rsv_addr = '0;
    idle();
    #2 reset = 1'b0;
    test_reset();
    test_bypass();
    test_priority();
    test_reserve();
    test_same_cycle();
    test_zero_r0();
    repeat (2) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
